// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: state codes, opcodes,
// instruction classes and the datapath select codes it drives.
package mc_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned EOP_W   = 2;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned NPC_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXE_R    = 4'd2,
    S_EXE_I    = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10
  } state_t;

  typedef enum logic [3:0] {
    C_NOP  = 4'd0,
    C_ADDU = 4'd1,
    C_SUBU = 4'd2,
    C_ORI  = 4'd3,
    C_LUI  = 4'd4,
    C_LW   = 4'd5,
    C_SW   = 4'd6,
    C_BEQ  = 4'd7,
    C_J    = 4'd8
  } cls_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;

  localparam logic [OP_W-1:0] FN_ADDU  = 6'h21;
  localparam logic [OP_W-1:0] FN_SUBU  = 6'h23;

  localparam logic [EOP_W-1:0] EXT_SIGN = 2'b00;
  localparam logic [EOP_W-1:0] EXT_ZERO = 2'b01;
  localparam logic [EOP_W-1:0] EXT_LUI  = 2'b10;
  localparam logic [EOP_W-1:0] EXT_BR   = 2'b11;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b010;

  localparam logic [NPC_W-1:0] NPC_SEQ = 2'b00;
  localparam logic [NPC_W-1:0] NPC_BR  = 2'b01;
  localparam logic [NPC_W-1:0] NPC_J   = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier; unsupported encodings map to NOP.
module mc_decode
  import mc_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [OP_W-1:0] funct,
  output cls_t            cls
);

  always_comb begin
    cls = C_NOP;
    case (op)
      OP_RTYPE: begin
        if (funct == FN_ADDU)      cls = C_ADDU;
        else if (funct == FN_SUBU) cls = C_SUBU;
      end
      OP_ORI:  cls = C_ORI;
      OP_LUI:  cls = C_LUI;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      OP_J:    cls = C_J;
      default: cls = C_NOP;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/write-back
// and drives all datapath enables and selects as Moore outputs.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [OP_W-1:0]    funct,
  input  logic               zero,
  output logic               pc_wr,
  output logic               ir_wr,
  output logic               grf_wr,
  output logic               dm_wr,
  output logic [EOP_W-1:0]   eop,
  output logic [ALU_W-1:0]   alu_op,
  output logic               alu_b_sel,
  output logic               wd_sel,
  output logic               a3_sel,
  output logic [NPC_W-1:0]   npc_sel,
  output logic [STATE_W-1:0] state
);

  state_t st;
  cls_t   cls;
  cls_t   dec_cls;

  mc_decode u_decode (
    .op    (op),
    .funct (funct),
    .cls   (dec_cls)
  );

  // State and latched instruction class; class is captured only in DECODE.
  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= S_FETCH;
      cls <= C_NOP;
    end else begin
      case (st)
        S_FETCH: st <= S_DECODE;
        S_DECODE: begin
          cls <= dec_cls;
          case (dec_cls)
            C_ADDU, C_SUBU: st <= S_EXE_R;
            C_ORI, C_LUI:   st <= S_EXE_I;
            C_LW, C_SW:     st <= S_MEM_ADDR;
            C_BEQ:          st <= S_BRANCH;
            C_J:            st <= S_JUMP;
            default:        st <= S_FETCH;
          endcase
        end
        S_EXE_R, S_EXE_I: st <= S_WB_ALU;
        S_MEM_ADDR:       st <= (cls == C_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:         st <= S_WB_MEM;
        default:          st <= S_FETCH;
      endcase
    end
  end

  assign state = st;

  // Moore output decode; reset overrides every output in the same cycle.
  always_comb begin
    pc_wr     = 1'b0;
    ir_wr     = 1'b0;
    grf_wr    = 1'b0;
    dm_wr     = 1'b0;
    eop       = EXT_SIGN;
    alu_op    = ALU_ADD;
    alu_b_sel = 1'b0;
    wd_sel    = 1'b0;
    a3_sel    = 1'b0;
    npc_sel   = NPC_SEQ;
    case (st)
      S_FETCH: begin
        ir_wr = 1'b1;
        pc_wr = 1'b1;
      end
      S_EXE_R, S_EXE_I, S_WB_ALU: begin
        case (cls)
          C_SUBU: alu_op = ALU_SUB;
          C_ORI: begin
            eop       = EXT_ZERO;
            alu_op    = ALU_OR;
            alu_b_sel = 1'b1;
          end
          C_LUI: begin
            eop       = EXT_LUI;
            alu_b_sel = 1'b1;
          end
          default: alu_op = ALU_ADD;
        endcase
        if (st == S_WB_ALU) begin
          grf_wr = 1'b1;
          a3_sel = (cls == C_ADDU) || (cls == C_SUBU);
        end
      end
      S_MEM_ADDR, S_MEM_RD: alu_b_sel = 1'b1;
      S_WB_MEM: begin
        grf_wr = 1'b1;
        wd_sel = 1'b1;
      end
      S_MEM_WR: begin
        dm_wr     = 1'b1;
        alu_b_sel = 1'b1;
      end
      S_BRANCH: begin
        alu_op  = ALU_SUB;
        eop     = EXT_BR;
        npc_sel = NPC_BR;
        pc_wr   = zero;
      end
      S_JUMP: begin
        npc_sel = NPC_J;
        pc_wr   = 1'b1;
      end
      default: pc_wr = 1'b0;
    endcase
    if (reset) begin
      pc_wr     = 1'b0;
      ir_wr     = 1'b0;
      grf_wr    = 1'b0;
      dm_wr     = 1'b0;
      eop       = EXT_SIGN;
      alu_op    = ALU_ADD;
      alu_b_sel = 1'b0;
      wd_sel    = 1'b0;
      a3_sel    = 1'b0;
      npc_sel   = NPC_SEQ;
    end
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the single-issue MIPS-subset datapath. It sequences instruction fetch, decode, execute, memory and write-back, and drives every datapath enable and mux select, including the immediate extender's `EOp`. It is the only stateful controller in the CPU; the datapath (PC, IR, GRF, ALU, DM, ext) holds no sequencing logic of its own.

## Interface
Parameters:
- none; encodings are fixed in the shared package.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clk`
- `op`  in  6  IR[31:26]; valid from the cycle after `ir_wr`
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU equality flag; meaningful in BRANCH only
- `pc_wr`  out  1  PC load enable
- `ir_wr`  out  1  IR load enable
- `grf_wr`  out  1  register-file write enable
- `dm_wr`  out  1  data-memory write enable
- `eop`  out  2  extender mode: 00 sign, 01 zero, 10 `{imm,16'b0}`, 11 sign<<2
- `alu_op`  out  3  000 add, 001 sub, 010 or
- `alu_b_sel`  out  1  0 = GRF rt, 1 = ext output
- `wd_sel`  out  1  GRF write data: 0 = ALU result, 1 = DM read data
- `a3_sel`  out  1  GRF write address: 0 = rt, 1 = rd
- `npc_sel`  out  2  00 PC+4, 01 PC+4+ext, 10 `{PC[31:28],instr_index,2'b00}`
- `state`  out  4  current state code, debug/verification only

## Operation
- Supported: `addu` (op 0, funct 0x21), `subu` (op 0, funct 0x23), `ori` (0x0D), `lui` (0x0F), `lw` (0x23), `sw` (0x2B), `beq` (0x04), `j` (0x02). Anything else (including op 0 with unknown funct) is a NOP.
- States: FETCH, DECODE, EXE_R, EXE_I, WB_ALU, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP.
- FETCH: `ir_wr`=1, `pc_wr`=1, `npc_sel`=00 -> DECODE.
- DECODE: classify `op`/`funct`, latch class into an internal register (used by all later states; `op`/`funct` are not re-sampled). Next: R -> EXE_R; ori/lui -> EXE_I; lw/sw -> MEM_ADDR; beq -> BRANCH; j -> JUMP; NOP -> FETCH.
- EXE_R: `alu_b_sel`=0, `alu_op` add/sub per funct -> WB_ALU.
- EXE_I: `alu_b_sel`=1; ori: `eop`=01, `alu_op`=or; lui: `eop`=10, `alu_op`=add (rs ignored; datapath forces A=0 for lui via `alu_op` add with zero register field) -> WB_ALU.
- WB_ALU: `grf_wr`=1, `wd_sel`=0, `a3_sel`=1 for R-type, 0 for ori/lui; ALU-side selects held from preceding EXE state -> FETCH.
- MEM_ADDR: `eop`=00, `alu_b_sel`=1, `alu_op`=add -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: address selects held -> WB_MEM. WB_MEM: `grf_wr`=1, `wd_sel`=1, `a3_sel`=0 -> FETCH.
- MEM_WR: `dm_wr`=1, address selects held -> FETCH.
- BRANCH: `alu_op`=sub, `alu_b_sel`=0, `eop`=11, `npc_sel`=01, `pc_wr`=`zero` -> FETCH.
- JUMP: `npc_sel`=10, `pc_wr`=1 -> FETCH.
- All outputs are Moore functions of (state, latched class); no output depends combinationally on `op`, `funct` except via the latch, and only `pc_wr` in BRANCH depends on `zero`.
- Unlisted output in a state is 0 (`eop` 00, `npc_sel` 00).

## Timing
- Reset: state FETCH; latched class NOP; all enables 0 during the reset cycle (FETCH enables gated by `reset`); first `ir_wr` pulse on the first edge after `reset` deasserts.
- CPI: R/ori/lui 4, lw 5, sw 4, beq 3, j 3, NOP 2.
- Exactly one `pc_wr` pulse per instruction in FETCH, plus at most one in BRANCH/JUMP; `grf_wr` and `dm_wr` never asserted in the same cycle and each at most one cycle per instruction.
- `reset` asserted in any state: next state FETCH regardless of pending write; a write enable active in that cycle is suppressed (reset has priority over all outputs).
- Illegal state encodings recover to FETCH next cycle.

## Structure
- Package `mc_pkg`: state codes, opcode/funct constants, `eop` codes (EXT_SIGN, EXT_ZERO, EXT_LUI, EXT_BR), `alu_op` codes, `npc_sel` codes, instruction-class codes.
- Sub-module `mc_decode`: combinational `op`,`funct` -> class; instantiated once, output latched in DECODE.

## Test plan
- Reset held 3 cycles then released, op=0x0D: all enables 0 during reset; `state` FETCH, DECODE, EXE_I (`eop`=01, `alu_op`=010), WB_ALU (`grf_wr`=1, `a3_sel`=0), FETCH.
- `lw` (op 0x23): five states, `eop`=00 in MEM_ADDR/MEM_RD, `grf_wr`=1 with `wd_sel`=1 only in WB_MEM; `dm_wr` never 1.
- `beq` with `zero`=1 then `zero`=0: BRANCH shows `eop`=11, `npc_sel`=01, `pc_wr`=1 then 0; both return to FETCH after 3 cycles.
- `lui` (0x0F) and `subu` (op 0, funct 0x23): `eop`=10 in EXE_I; `alu_op`=001 and `a3_sel`=1 for subu.
- op=0x3F and op 0/funct 0x00: DECODE -> FETCH, no `grf_wr`/`dm_wr`/extra `pc_wr`.
- `reset` asserted in MEM_WR during `sw`: `dm_wr`=0 that cycle, next `state` FETCH.
